// File: rtl/draw_pkg.sv
// Shared types and helpers for the sprite draw sequencer: command record,
// screen bounds, sequencer state encoding and rectangle clipping.
package draw_pkg;

   localparam int unsigned SRC_ADDR_W = 14;  // keep equal to SrcAddrWidth
   localparam int unsigned SCREEN_W   = 640;
   localparam int unsigned SCREEN_H   = 480;

   typedef struct packed {
      logic [9:0]            x;
      logic [9:0]            y;
      logic [9:0]            w;
      logic [9:0]            h;
      logic [SRC_ADDR_W-1:0] src;
      logic                  flip;
   } draw_cmd_t;

   typedef enum logic [2:0] {
      StIdle,
      StFetch,
      StCheck,
      StRun,
      StRelease
   } draw_state_t;

   // Exclusive end coordinate, summed at 11 bits and saturated at the screen edge.
   function automatic logic [9:0] clip_end(input logic [9:0]  start,
                                           input logic [9:0]  len,
                                           input logic [10:0] limit);
      logic [10:0] sum;
      sum = {1'b0, start} + {1'b0, len};
      return (sum > limit) ? limit[9:0] : sum[9:0];
   endfunction

   function automatic logic is_degenerate(input draw_cmd_t cmd);
      return (cmd.w == '0) || (cmd.h == '0) ||
             (cmd.x >= 10'(SCREEN_W)) || (cmd.y >= 10'(SCREEN_H));
   endfunction

endpackage

// File: rtl/draw_cmd_fifo.sv
// Synchronous FIFO of draw commands with a registered read port and
// occupancy count; full is registered from the next-state count.
module draw_cmd_fifo
   import draw_pkg::*;
#(
   parameter int unsigned Depth = 16
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         push,
   input  draw_cmd_t                    push_data,
   input  logic                         pop,
   output draw_cmd_t                    pop_data,
   output logic [$clog2(Depth+1)-1:0]   count,
   output logic                         full
);

   localparam int unsigned PtrW   = $clog2(Depth);
   localparam int unsigned CountW = $clog2(Depth + 1);

   draw_cmd_t         mem_q [Depth];
   logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [CountW-1:0] count_q, count_d;
   logic              full_q, full_d;
   draw_cmd_t         pop_data_q, pop_data_d;
   logic              wr_en, rd_en;

   always_comb begin
      wr_en      = push & ~full_q;
      rd_en      = pop & (count_q != '0);
      wr_ptr_d   = wr_ptr_q + PtrW'(wr_en);
      rd_ptr_d   = rd_ptr_q + PtrW'(rd_en);
      count_d    = count_q + CountW'(wr_en) - CountW'(rd_en);
      full_d     = (count_d == CountW'(Depth));
      pop_data_d = rd_en ? mem_q[rd_ptr_q] : pop_data_q;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         full_q     <= 1'b0;
         pop_data_q <= '0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         full_q     <= full_d;
         pop_data_q <= pop_data_d;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_q[wr_ptr_q] <= push_data;
      end
   end

   assign pop_data = pop_data_q;
   assign count    = count_q;
   assign full     = full_q;

endmodule

// File: rtl/sprite_draw_queue.sv
// Frame-synchronous sequencer: snapshots the queued sprite commands on
// frame_start and feeds them one by one through the copy_engine handshake.
module sprite_draw_queue
   import draw_pkg::*;
#(
   parameter int unsigned SrcAddrWidth = 14,
   parameter int unsigned Depth        = 16
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    push,
   input  logic [9:0]              push_x,
   input  logic [9:0]              push_y,
   input  logic [9:0]              push_w,
   input  logic [9:0]              push_h,
   input  logic [SrcAddrWidth-1:0] push_src,
   input  logic                    push_flip,
   output logic                    full,
   input  logic                    frame_start,
   output logic [9:0]              dest_x_start,
   output logic [9:0]              dest_x_end,
   output logic [9:0]              dest_y_start,
   output logic [9:0]              dest_y_end,
   output logic [SrcAddrWidth-1:0] src_addr_start,
   output logic                    flip_x,
   output logic                    execute,
   input  logic                    done,
   output logic                    busy,
   output logic                    frame_done,
   output logic                    overrun
);

   localparam int unsigned CountW = $clog2(Depth + 1);

   draw_cmd_t         push_cmd, cur_cmd;
   logic [CountW-1:0] fifo_count;
   logic [CountW-1:0] remaining_q, remaining_d;
   draw_state_t       state_q, state_d;
   logic [9:0]        x_end_q, x_end_d, y_end_q, y_end_d;
   logic              execute_q, execute_d, busy_q, busy_d;
   logic              frame_done_q, frame_done_d, overrun_q, overrun_d;
   logic              pop;

   assign push_cmd = '{x: push_x, y: push_y, w: push_w, h: push_h,
                       src: push_src, flip: push_flip};

   draw_cmd_fifo #(
      .Depth(Depth)
   ) u_fifo (
      .clk      (clk),
      .reset    (reset),
      .push     (push),
      .push_data(push_cmd),
      .pop      (pop),
      .pop_data (cur_cmd),
      .count    (fifo_count),
      .full     (full)
   );

   // The FIFO read is issued one state early so the head is already registered in FETCH.
   always_comb begin
      state_d      = state_q;
      remaining_d  = remaining_q;
      x_end_d      = x_end_q;
      y_end_d      = y_end_q;
      execute_d    = 1'b0;
      frame_done_d = 1'b0;
      pop          = 1'b0;
      overrun_d    = overrun_q | (frame_start & (state_q != StIdle));
      case (state_q)
         StIdle: begin
            if (frame_start) begin
               remaining_d = fifo_count;
               if (fifo_count == '0) begin
                  frame_done_d = 1'b1;
               end else begin
                  pop     = 1'b1;
                  state_d = StFetch;
               end
            end
         end
         StFetch: begin
            remaining_d = remaining_q - CountW'(1);
            x_end_d     = clip_end(cur_cmd.x, cur_cmd.w, 11'(SCREEN_W));
            y_end_d     = clip_end(cur_cmd.y, cur_cmd.h, 11'(SCREEN_H));
            state_d     = StCheck;
         end
         StCheck: begin
            if (!is_degenerate(cur_cmd)) begin
               execute_d = 1'b1;
               state_d   = StRun;
            end else if (remaining_q != '0) begin
               pop     = 1'b1;
               state_d = StFetch;
            end else begin
               frame_done_d = 1'b1;
               state_d      = StIdle;
            end
         end
         StRun: begin
            if (done) begin
               state_d = StRelease;
            end else begin
               execute_d = 1'b1;
            end
         end
         StRelease: begin
            if (remaining_q != '0) begin
               pop     = 1'b1;
               state_d = StFetch;
            end else begin
               frame_done_d = 1'b1;
               state_d      = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
      busy_d = (state_d != StIdle);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= StIdle;
         remaining_q  <= '0;
         x_end_q      <= '0;
         y_end_q      <= '0;
         execute_q    <= 1'b0;
         busy_q       <= 1'b0;
         frame_done_q <= 1'b0;
         overrun_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         remaining_q  <= remaining_d;
         x_end_q      <= x_end_d;
         y_end_q      <= y_end_d;
         execute_q    <= execute_d;
         busy_q       <= busy_d;
         frame_done_q <= frame_done_d;
         overrun_q    <= overrun_d;
      end
   end

   assign dest_x_start   = cur_cmd.x;
   assign dest_y_start   = cur_cmd.y;
   assign dest_x_end     = x_end_q;
   assign dest_y_end     = y_end_q;
   assign src_addr_start = cur_cmd.src;
   assign flip_x         = cur_cmd.flip;
   assign execute        = execute_q;
   assign busy           = busy_q;
   assign frame_done     = frame_done_q;
   assign overrun        = overrun_q;

endmodule
